// File: rtl/pulse_burst_pkg.sv
// Shared state encoding for the tick-paced pulse burst sequencer.
package pulse_burst_pkg;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_HIGH_ENC = 2'd1;
   localparam logic [1:0] ST_LOW_ENC  = 2'd2;
   localparam logic [1:0] ST_DONE_ENC = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE_ENC,
      HIGH = ST_HIGH_ENC,
      LOW  = ST_LOW_ENC,
      DONE = ST_DONE_ENC
   } state_t;

endpackage

// File: rtl/pulse_burst_sequencer.sv
// Tick-paced burst generator: count pulses of high/low ticks, then a done strobe.
// Optional BURST_ABORT_EN adds an abort input that ends the burst early.
module pulse_burst_sequencer
   import pulse_burst_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [CNT_W-1:0] cmd_high,
   input  logic [CNT_W-1:0] cmd_low,
   output logic             pulse_o,
   output logic             busy,
   output logic             done
`ifdef BURST_ABORT_EN
   ,
   input  logic             abort
`endif
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_ph;
   logic [CNT_W-1:0] w_nextPh;
   logic [CNT_W-1:0] r_left;
   logic [CNT_W-1:0] w_nextLeft;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] w_nextHigh;
   logic [CNT_W-1:0] r_low;
   logic [CNT_W-1:0] w_nextLow;
   logic             w_abort;

`ifdef BURST_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_ph    <= '0;
         r_left  <= '0;
         r_high  <= '0;
         r_low   <= '0;
      end else begin
         r_state <= w_nextState;
         r_ph    <= w_nextPh;
         r_left  <= w_nextLeft;
         r_high  <= w_nextHigh;
         r_low   <= w_nextLow;
      end
   end

   // Phase lengths of zero are stored as one so the terminal compare never underflows.
   always_comb begin
      w_nextState = r_state;
      w_nextPh    = r_ph;
      w_nextLeft  = r_left;
      w_nextHigh  = r_high;
      w_nextLow   = r_low;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_nextLeft  = cmd_count;
               w_nextHigh  = (cmd_high == '0) ? ONE : cmd_high;
               w_nextLow   = (cmd_low == '0) ? ONE : cmd_low;
               w_nextPh    = '0;
               w_nextState = (cmd_count == '0) ? DONE : HIGH;
            end
         end
         HIGH: begin
            if (w_abort) begin
               w_nextPh    = '0;
               w_nextState = DONE;
            end else if (tick) begin
               if (r_ph == r_high - ONE) begin
                  w_nextPh    = '0;
                  w_nextState = (r_left == ONE) ? DONE : LOW;
               end else begin
                  w_nextPh = r_ph + ONE;
               end
            end
         end
         LOW: begin
            if (w_abort) begin
               w_nextPh    = '0;
               w_nextState = DONE;
            end else if (tick) begin
               if (r_ph == r_low - ONE) begin
                  w_nextPh    = '0;
                  w_nextLeft  = r_left - ONE;
                  w_nextState = HIGH;
               end else begin
                  w_nextPh = r_ph + ONE;
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign pulse_o   = (r_state == HIGH);
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign cmd_ready = (r_state == IDLE);

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Directed bench for pulse_burst_sequencer with a tick on every 4th clock edge.
module tb_pulse_burst_sequencer;

   logic       clk;
   logic       reset_n;
   logic       tick;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_count;
   logic [7:0] cmd_high;
   logic [7:0] cmd_low;
   logic       pulse_o;
   logic       busy;
   logic       done;
   logic       abort;

   int testsRun;
   int testsFailed;
   int tickPhase;

   pulse_burst_sequencer #(.CNT_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_count (cmd_count),
      .cmd_high  (cmd_high),
      .cmd_low   (cmd_low),
      .pulse_o   (pulse_o),
      .busy      (busy),
      .done      (done)
`ifdef BURST_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock, then schedule the tick for the following edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
      tickPhase = (tickPhase + 1) % 4;
      tick = (tickPhase == 0);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      @(posedge clk);
      #1;
      testsRun++;
      if ({pulse_o, busy, done} !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL reset_hold: {pulse,busy,done}=%b required 000", {pulse_o, busy, done});
      end
      reset_n = 1'b1;
      nextCycle();
      testsRun++;
      if ({cmd_ready, pulse_o, busy, done} !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL reset_release: {ready,pulse,busy,done}=%b required 1000",
                  {cmd_ready, pulse_o, busy, done});
      end
   endtask

   task automatic test_reset_mid_burst();
      int doneSeen;
      cmd_count = 8'd3; cmd_high = 8'd2; cmd_low = 8'd1;
      tickPhase = 0; tick = 1'b1; cmd_valid = 1'b1;
      nextCycle();
      cmd_valid = 1'b0;
      nextCycle();
      nextCycle();
      testsRun++;
      if ({pulse_o, busy} !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL midreset_pre: {pulse,busy}=%b required 11", {pulse_o, busy});
      end
      reset_n = 1'b0;
      #1;
      testsRun++;
      if ({pulse_o, busy, done} !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL midreset_async: {pulse,busy,done}=%b required 000", {pulse_o, busy, done});
      end
      #1;
      reset_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         nextCycle();
         if (done || pulse_o) doneSeen++;
      end
      testsRun++;
      if (doneSeen !== 0 || cmd_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL midreset_after: done/pulse cycles=%0d ready=%b required 0 and 1",
                  doneSeen, cmd_ready);
      end
   endtask

   task automatic test_count3();
      logic expP, expB, expD;
      cmd_count = 8'd3; cmd_high = 8'd2; cmd_low = 8'd1;
      tickPhase = 0; tick = 1'b1; cmd_valid = 1'b1;
      nextCycle();
      cmd_valid = 1'b0;
      for (int i = 0; i < 36; i++) begin
         expP = (i < 8) || (i >= 12 && i < 20) || (i >= 24 && i < 32);
         expD = (i == 32);
         expB = (i <= 32);
         testsRun++;
         if ({pulse_o, busy, done} !== {expP, expB, expD}) begin
            testsFailed++;
            $display("[TB] FAIL count3 cycle %0d: {pulse,busy,done}=%b required %b",
                     i, {pulse_o, busy, done}, {expP, expB, expD});
         end
         nextCycle();
      end
   endtask

   task automatic test_count0();
      cmd_count = 8'd0; cmd_high = 8'd4; cmd_low = 8'd4;
      cmd_valid = 1'b1;
      nextCycle();
      cmd_valid = 1'b0;
      testsRun++;
      if ({cmd_ready, pulse_o, busy, done} !== 4'b0011) begin
         testsFailed++;
         $display("[TB] FAIL count0_done: {ready,pulse,busy,done}=%b required 0011",
                  {cmd_ready, pulse_o, busy, done});
      end
      nextCycle();
      testsRun++;
      if ({cmd_ready, pulse_o, busy, done} !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL count0_idle: {ready,pulse,busy,done}=%b required 1000",
                  {cmd_ready, pulse_o, busy, done});
      end
   endtask

   task automatic test_zero_phases_hold_valid();
      logic expP, expB, expD, expR;
      cmd_count = 8'd2; cmd_high = 8'd0; cmd_low = 8'd0;
      tickPhase = 3; tick = 1'b0; cmd_valid = 1'b1;
      nextCycle();
      cmd_count = 8'd1; cmd_high = 8'd3; cmd_low = 8'd0;
      for (int i = 0; i < 25; i++) begin
         expP = (i == 0) || (i >= 5 && i < 9) || (i >= 11 && i < 21);
         expD = (i == 9) || (i == 21);
         expB = (i <= 9) || (i >= 11 && i <= 21);
         expR = (i == 10) || (i >= 22);
         testsRun++;
         if ({cmd_ready, pulse_o, busy, done} !== {expR, expP, expB, expD}) begin
            testsFailed++;
            $display("[TB] FAIL zerophase cycle %0d: {ready,pulse,busy,done}=%b required %b",
                     i, {cmd_ready, pulse_o, busy, done}, {expR, expP, expB, expD});
         end
         if (i == 11) cmd_valid = 1'b0;
         nextCycle();
      end
   endtask

   task automatic test_count_max();
      int  rises;
      int  doneAt;
      logic prev;
      cmd_count = 8'd255; cmd_high = 8'd1; cmd_low = 8'd1;
      tickPhase = 0; tick = 1'b1; cmd_valid = 1'b1;
      nextCycle();
      cmd_valid = 1'b0;
      rises  = 0;
      doneAt = -1;
      prev   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (pulse_o && !prev) rises++;
         prev = pulse_o;
         if (done) begin
            doneAt = i;
            break;
         end
         nextCycle();
      end
      testsRun++;
      if (doneAt !== 2036 || rises !== 255) begin
         testsFailed++;
         $display("[TB] FAIL count255: pulses=%0d done_cycle=%0d required 255 and 2036", rises, doneAt);
      end
      nextCycle();
   endtask

`ifdef BURST_ABORT_EN
   task automatic test_abort();
      logic expP, expB, expD;
      int   rises;
      logic prev;
      cmd_count = 8'd5; cmd_high = 8'd1; cmd_low = 8'd2;
      tickPhase = 0; tick = 1'b1; cmd_valid = 1'b1;
      nextCycle();
      cmd_valid = 1'b0;
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 26; i++) begin
         expP = (i < 4) || (i >= 12 && i < 16);
         expD = (i == 18);
         expB = (i <= 18);
         if (pulse_o && !prev) rises++;
         prev = pulse_o;
         testsRun++;
         if ({pulse_o, busy, done} !== {expP, expB, expD}) begin
            testsFailed++;
            $display("[TB] FAIL abort cycle %0d: {pulse,busy,done}=%b required %b",
                     i, {pulse_o, busy, done}, {expP, expB, expD});
         end
         abort = (i == 17);
         nextCycle();
      end
      testsRun++;
      if (rises !== 2) begin
         testsFailed++;
         $display("[TB] FAIL abort_pulses: pulses=%0d required 2", rises);
      end
      abort = 1'b1;
      nextCycle();
      nextCycle();
      abort = 1'b0;
      testsRun++;
      if ({cmd_ready, busy, done} !== 3'b100) begin
         testsFailed++;
         $display("[TB] FAIL abort_idle: {ready,busy,done}=%b required 100", {cmd_ready, busy, done});
      end
   endtask
`endif

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      tickPhase   = 1;
      tick        = 1'b0;
      cmd_valid   = 1'b0;
      cmd_count   = '0;
      cmd_high    = '0;
      cmd_low     = '0;
      abort       = 1'b0;
      reset_n     = 1'b0;
      test_reset();
      test_reset_mid_burst();
      test_count3();
      test_count0();
      test_zero_phases_hold_valid();
      test_count_max();
`ifdef BURST_ABORT_EN
      test_abort();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
